// File: rtl/universal_shift_unit.sv
// Universal shift unit: load, logical/ring shifts by a runtime amount, serial out/in, with start/busy/done.
// Define SHIFT_BARREL_EN to complete SHL/SHR/ROL/ROR in a single cycle through a barrel shifter.
module universal_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_SHL    = 3'd2;
    localparam logic [2:0] OP_SHR    = 3'd3;
    localparam logic [2:0] OP_ROL    = 3'd4;
    localparam logic [2:0] OP_ROR    = 3'd5;
    localparam logic [2:0] OP_SER_IN = 3'd7;

    localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_SERIAL,
        ST_FIN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] cnt_q;
    logic [AMT_W-1:0] tgt_q;
    logic             busy_q;
    logic             done_q;

    // Rotations only need the residue; logical shifts keep the full count so the latency tracks amt.
    function automatic logic [AMT_W-1:0] eff_amt(input logic [2:0] o, input logic [AMT_W-1:0] a);
        if (o == OP_ROL || o == OP_ROR) begin
            eff_amt = a % WIDTH_A;
        end else begin
            eff_amt = a;
        end
    endfunction

    function automatic logic [WIDTH-1:0] step(input logic [2:0] o, input logic [WIDTH-1:0] v,
                                              input logic s);
        case (o)
            OP_SHL:    step = {v[WIDTH-2:0], 1'b0};
            OP_SHR:    step = {1'b0, v[WIDTH-1:1]};
            OP_ROL:    step = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:    step = {v[0], v[WIDTH-1:1]};
            OP_SER_IN: step = {s, v[WIDTH-1:1]};
            default:   step = {1'b0, v[WIDTH-1:1]};
        endcase
    endfunction

`ifdef SHIFT_BARREL_EN
    function automatic logic [WIDTH-1:0] barrel(input logic [2:0] o, input logic [WIDTH-1:0] v,
                                                input logic [AMT_W-1:0] a);
        logic [AMT_W-1:0] r;
        r = a % WIDTH_A;
        case (o)
            OP_SHL:  barrel = (a >= WIDTH_A) ? '0 : (v << a);
            OP_SHR:  barrel = (a >= WIDTH_A) ? '0 : (v >> a);
            OP_ROL:  barrel = (v << r) | (v >> (WIDTH_A - r));
            OP_ROR:  barrel = (v >> r) | (v << (WIDTH_A - r));
            default: barrel = v;
        endcase
    endfunction
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            tgt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && op != OP_NOP) begin
                        op_q  <= op;
                        cnt_q <= '0;
                        case (op)
                            OP_LOAD: begin
                                data_q  <= d;
                                state_q <= ST_FIN;
                                done_q  <= 1'b1;
                            end
                            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
`ifdef SHIFT_BARREL_EN
                                data_q  <= barrel(op, data_q, amt);
                                state_q <= ST_FIN;
                                done_q  <= 1'b1;
`else
                                if (eff_amt(op, amt) == '0) begin
                                    state_q <= ST_FIN;
                                    done_q  <= 1'b1;
                                end else begin
                                    tgt_q   <= eff_amt(op, amt);
                                    state_q <= ST_SHIFT;
                                    busy_q  <= 1'b1;
                                end
`endif
                            end
                            default: begin
                                tgt_q   <= WIDTH_A;
                                state_q <= ST_SERIAL;
                                busy_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_SHIFT, ST_SERIAL: begin
                    data_q <= step(op_q, data_q, ser_in);
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == tgt_q) begin
                        state_q <= ST_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign q       = data_q;
    assign ser_out = data_q[0];
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
